// File: rtl/nabp_angle_scheduler_if.sv
// Host angle handshake between the angle scheduler and the swap controller.
//   next_angle      : request level from the swap controller
//   angle           : angle offered by the scheduler
//   has_next_angle  : an unissued angle is on `angle`
//   next_angle_ack  : one-cycle acknowledge of an accepted request
//   sino_base       : sinogram RAM row base for the offered angle
// Modports: master = swap controller (requester), slave = scheduler (responder).
interface nabp_angle_scheduler_if #(
  parameter int ANGLE_WIDTH = 9,
  parameter int ADDR_WIDTH  = 16
);
  logic                   next_angle;
  logic [ANGLE_WIDTH-1:0] angle;
  logic                   has_next_angle;
  logic                   next_angle_ack;
  logic [ADDR_WIDTH-1:0]  sino_base;

  modport master (
    output next_angle,
    input  angle, has_next_angle, next_angle_ack, sino_base
  );

  modport slave (
    input  next_angle,
    output angle, has_next_angle, next_angle_ack, sino_base
  );
endinterface

// File: rtl/nabp_angle_scheduler.sv
// nabp_angle_scheduler: sequences one scan of projection angles.
// A start pulse latches the scan configuration; each request on the host
// handshake is answered ACK_LATENCY+1 cycles later with a one-cycle ack while
// angle / sino_base / has_next_angle hold the delivered projection. After the
// last ack, done pulses and busy drops in the same cycle.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start             : begin a scan when idle
//   cfg_first_angle   : first angle (< ANGLE_LIMIT)
//   cfg_angle_step    : increment (< ANGLE_LIMIT), wraps modulo ANGLE_LIMIT
//   cfg_num_angles    : projections per scan (0 = immediate done)
//   abort             : only with NABP_ANGLE_SCHED_ABORT_EN; level, ends scan
//   busy, done        : scan in progress / one-cycle completion pulse
//   hs                : angle handshake (slave side)
// Optional feature macro: NABP_ANGLE_SCHED_ABORT_EN.
module nabp_angle_scheduler #(
  parameter int ANGLE_WIDTH = 9,
  parameter int ANGLE_LIMIT = 180,
  parameter int COUNT_WIDTH = 9,
  parameter int ADDR_WIDTH  = 16,
  parameter int S_COUNT     = 256,
  parameter int ACK_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ANGLE_WIDTH-1:0] cfg_first_angle,
  input  logic [ANGLE_WIDTH-1:0] cfg_angle_step,
  input  logic [COUNT_WIDTH-1:0] cfg_num_angles,
`ifdef NABP_ANGLE_SCHED_ABORT_EN
  input  logic                   abort,
`endif
  output logic                   busy,
  output logic                   done,
  nabp_angle_scheduler_if.slave  hs
);

  localparam int LAT_W = (ACK_LATENCY > 1) ? $clog2(ACK_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD =
    LAT_W'((ACK_LATENCY > 0) ? ACK_LATENCY - 1 : 0);

  typedef enum logic [1:0] {IDLE, READY, LAT, ACK} state_t;

  typedef struct packed {
    logic [ANGLE_WIDTH-1:0] step;
    logic [COUNT_WIDTH-1:0] num;
  } cfg_t;

  state_t                 state, state_nxt;
  cfg_t                   cfg_q;
  logic [COUNT_WIDTH-1:0] index;
  logic [LAT_W-1:0]       lat_cnt;
  logic [ANGLE_WIDTH-1:0] angle_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic                   has_next_q, ack_q, busy_q, done_q;

  logic                   abort_w;
  logic                   accept, last;
  logic [COUNT_WIDTH:0]   idx_inc;
  logic [ANGLE_WIDTH:0]   sum;
  logic [ANGLE_WIDTH-1:0] angle_adv;

`ifdef NABP_ANGLE_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign accept  = hs.next_angle && has_next_q;
  assign idx_inc = {1'b0, index} + (COUNT_WIDTH+1)'(1);
  assign last    = (idx_inc >= {1'b0, cfg_q.num});

  // One extra bit keeps the carry so the wrap compare is exact.
  assign sum       = {1'b0, angle_q} + {1'b0, cfg_q.step};
  assign angle_adv = (sum >= (ANGLE_WIDTH+1)'(ANGLE_LIMIT))
                   ? ANGLE_WIDTH'(sum - (ANGLE_WIDTH+1)'(ANGLE_LIMIT))
                   : sum[ANGLE_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start && (cfg_num_angles != '0)) state_nxt = READY;
      READY: if (accept) state_nxt = (ACK_LATENCY == 0) ? ACK : LAT;
      LAT:   if (lat_cnt == '0) state_nxt = ACK;
      ACK:   state_nxt = last ? IDLE : READY;
      default: state_nxt = IDLE;
    endcase
    // Abort wins over everything; an ack already on the wire this cycle
    // has been delivered, any later one is dropped by leaving LAT/READY.
    if (abort_w && (state != IDLE)) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q      <= '0;
      index      <= '0;
      lat_cnt    <= '0;
      angle_q    <= '0;
      base_q     <= '0;
      has_next_q <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // Ack is registered off the next state so it lines up with ACK.
      ack_q  <= (state_nxt == ACK);
      done_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cfg_q.step <= cfg_angle_step;
          cfg_q.num  <= cfg_num_angles;
          angle_q    <= cfg_first_angle;
          index      <= '0;
          base_q     <= '0;
          if (cfg_num_angles != '0) begin
            has_next_q <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            done_q <= 1'b1;
          end
        end
        READY: if (accept) lat_cnt <= LAT_LOAD;
        LAT:   lat_cnt <= lat_cnt - LAT_W'(1);
        ACK: begin
          index   <= idx_inc[COUNT_WIDTH-1:0];
          angle_q <= angle_adv;
          base_q  <= base_q + ADDR_WIDTH'(S_COUNT);
          if (last) begin
            has_next_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        default: ;
      endcase
      if (abort_w && (state != IDLE)) begin
        has_next_q <= 1'b0;
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
      end
    end
  end

  assign hs.angle          = angle_q;
  assign hs.sino_base      = base_q;
  assign hs.has_next_angle = has_next_q;
  assign hs.next_angle_ack = ack_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule
